// File: rtl/div_ctrl.sv
// div_ctrl: front-end sequencer for an unsigned iterative divider core.
// Accepts RV32M DIV/DIVU/REM/REMU requests and resolves divide-by-zero and
// signed overflow locally. Every other request goes to the core as unsigned
// magnitudes. The core's result gets its sign restored and is returned with
// the request tag.
// Optional build macro: DIV_CTRL_REUSE_EN keeps the last core-computed
// operands/results so that a matching request skips the core.
module div_ctrl #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             core_in_valid_o,
  input  logic             core_in_ready_i,
  output logic [WIDTH-1:0] core_a_o,
  output logic [WIDTH-1:0] core_b_o,
  input  logic             core_out_valid_i,
  output logic             core_out_ready_o,
  input  logic [WIDTH-1:0] core_quot_i,
  input  logic [WIDTH-1:0] core_rem_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mag_a_reg, mag_b_reg, data_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             want_rem_reg, neg_q_reg, neg_r_reg;

  logic             accept;
  logic             acc_signed, acc_rem, acc_neg_q, acc_neg_r, acc_short;
  logic [WIDTH-1:0] acc_mag_a, acc_mag_b, acc_data;
  logic [WIDTH-1:0] core_result;

  // Two's complement negate when requested; -MIN wraps to MIN as intended.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept      = req_valid_i && req_ready_o;
  assign core_result = apply_sign(want_rem_reg ? core_rem_i : core_quot_i,
                                  want_rem_reg ? neg_r_reg : neg_q_reg);
  assign core_a_o    = mag_a_reg;
  assign core_b_o    = mag_b_reg;
  assign rsp_data_o  = data_reg;
  assign rsp_tag_o   = tag_reg;

`ifdef DIV_CTRL_REUSE_EN
  logic [WIDTH-1:0] cur_a_reg, cur_b_reg, cache_a_reg, cache_b_reg, cache_q_reg, cache_r_reg;
  logic             cur_signed_reg, cache_signed_reg, cache_valid_reg;
`endif

  // Decode the incoming request: magnitudes, result signs, and short-path results
  always_comb begin
    acc_signed = ~req_op_i[0];
    acc_rem    = req_op_i[1];
    acc_mag_a  = (acc_signed && req_a_i[WIDTH-1]) ? -req_a_i : req_a_i;
    acc_mag_b  = (acc_signed && req_b_i[WIDTH-1]) ? -req_b_i : req_b_i;
    acc_neg_q  = acc_signed && (req_a_i[WIDTH-1] ^ req_b_i[WIDTH-1]);
    acc_neg_r  = acc_signed && req_a_i[WIDTH-1];
    acc_short  = 1'b0;
    acc_data   = '0;
    if (req_b_i == '0) begin
      acc_short = 1'b1;
      acc_data  = acc_rem ? req_a_i : ALL_ONES;
    end else if (acc_signed && (req_a_i == MIN_NEG) && (req_b_i == ALL_ONES)) begin
      acc_short = 1'b1;
      acc_data  = acc_rem ? '0 : req_a_i;
    end
`ifdef DIV_CTRL_REUSE_EN
    else if (cache_valid_reg && (req_a_i == cache_a_reg) && (req_b_i == cache_b_reg) &&
             (acc_signed == cache_signed_reg)) begin
      acc_short = 1'b1;
      acc_data  = apply_sign(acc_rem ? cache_r_reg : cache_q_reg,
                             acc_rem ? acc_neg_r : acc_neg_q);
    end
`endif
  end

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = acc_short ? RESP : ISSUE;
      ISSUE:   if (core_in_ready_i) state_next = WAIT;
      WAIT:    if (core_out_valid_i) state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = accept ? (acc_short ? RESP : ISSUE) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    req_ready_o      = 1'b0;
    rsp_valid_o      = 1'b0;
    core_in_valid_o  = 1'b0;
    core_out_ready_o = 1'b0;
    busy_o           = (state_reg != IDLE);
    case (state_reg)
      IDLE:  req_ready_o = 1'b1;
      ISSUE: core_in_valid_o = 1'b1;
      WAIT:  core_out_ready_o = 1'b1;
      RESP: begin
        rsp_valid_o = 1'b1;
        req_ready_o = rsp_ready_i;
      end
      default: ;
    endcase
  end

  // Capture request context on accept and the signed result on core completion
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      mag_a_reg    <= '0;
      mag_b_reg    <= '0;
      data_reg     <= '0;
      tag_reg      <= '0;
      want_rem_reg <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
    end else if (accept) begin
      mag_a_reg    <= acc_mag_a;
      mag_b_reg    <= acc_mag_b;
      tag_reg      <= req_tag_i;
      want_rem_reg <= acc_rem;
      neg_q_reg    <= acc_neg_q;
      neg_r_reg    <= acc_neg_r;
      if (acc_short) data_reg <= acc_data;
    end else if ((state_reg == WAIT) && core_out_valid_i) begin
      data_reg <= core_result;
    end
  end

`ifdef DIV_CTRL_REUSE_EN
  // Remember the raw operands of the op in flight and store each core result
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cur_a_reg        <= '0;
      cur_b_reg        <= '0;
      cur_signed_reg   <= 1'b0;
      cache_a_reg      <= '0;
      cache_b_reg      <= '0;
      cache_signed_reg <= 1'b0;
      cache_q_reg      <= '0;
      cache_r_reg      <= '0;
      cache_valid_reg  <= 1'b0;
    end else if (accept) begin
      cur_a_reg      <= req_a_i;
      cur_b_reg      <= req_b_i;
      cur_signed_reg <= acc_signed;
    end else if ((state_reg == WAIT) && core_out_valid_i) begin
      cache_a_reg      <= cur_a_reg;
      cache_b_reg      <= cur_b_reg;
      cache_signed_reg <= cur_signed_reg;
      cache_q_reg      <= core_quot_i;
      cache_r_reg      <= core_rem_i;
      cache_valid_reg  <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized self-checking bench for div_ctrl with a behavioural
// divider core, a stalling response consumer and an RV32M reference model.
module tb_div_ctrl;
  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic              clock = 1'b0;
  logic              nreset = 1'b0;
  logic              req_valid_i = 1'b0, req_ready_o;
  logic [1:0]        req_op_i = '0;
  logic [WIDTH-1:0]  req_a_i = '0, req_b_i = '0;
  logic [TAG_W-1:0]  req_tag_i = '0;
  logic              rsp_valid_o, rsp_ready_i = 1'b0;
  logic [WIDTH-1:0]  rsp_data_o;
  logic [TAG_W-1:0]  rsp_tag_o;
  logic              core_in_valid_o, core_in_ready_i = 1'b0;
  logic [WIDTH-1:0]  core_a_o, core_b_o;
  logic              core_out_valid_i = 1'b0, core_out_ready_o;
  logic [WIDTH-1:0]  core_quot_i = '0, core_rem_i = '0;
  logic              busy_o;

  always #5 clock = ~clock;

  div_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .nreset(nreset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_tag_o(rsp_tag_o),
    .core_in_valid_o(core_in_valid_o), .core_in_ready_i(core_in_ready_i),
    .core_a_o(core_a_o), .core_b_o(core_b_o),
    .core_out_valid_i(core_out_valid_i), .core_out_ready_o(core_out_ready_o),
    .core_quot_i(core_quot_i), .core_rem_i(core_rem_i), .busy_o(busy_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tag;
  } req_t;

  typedef struct {
    logic [31:0] a, b, data, mag_a, mag_b;
    logic [4:0]  tag;
    bit          signed_op, short_path, seen;
    int          acc_cyc;
  } exp_t;

  req_t req_q[$];
  exp_t exp_q[$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0, core_xfers = 0, normal_accepts = 0;
  int in_stall_len = 0, rsp_stall_len = 0, core_lat = 2;
  int in_stall_cnt = 0, rsp_stall_cnt = 0, lat_cnt = 0;
  bit core_pend = 0;
  logic [31:0] core_q = '0, core_r = '0;
  // reuse model: operands of the most recent result produced by the core
  logic [31:0] last_a = '0, last_b = '0;
  bit last_s = 0, last_v = 0;
  bit hold_rsp = 0, hold_core = 0;
  logic [31:0] hold_data = '0, hold_ca = '0, hold_cb = '0;
  logic [4:0]  hold_tag = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // RV32M semantics straight from the instruction definitions
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] v, input bit s);
    int sv = v;
    return (s && sv < 0) ? 32'(-sv) : v;
  endfunction

  function automatic exp_t build_exp(input req_t r);
    exp_t e;
    bit special;
    e.a = r.a; e.b = r.b; e.tag = r.tag;
    e.signed_op = !r.op[0];
    e.data  = ref_result(r.op, r.a, r.b);
    e.mag_a = magnitude(r.a, e.signed_op);
    e.mag_b = magnitude(r.b, e.signed_op);
    special = (r.b == 0) || (e.signed_op && r.a == 32'h8000_0000 && r.b == 32'hFFFF_FFFF);
    e.short_path = special;
`ifdef DIV_CTRL_REUSE_EN
    if (last_v && r.a == last_a && r.b == last_b && e.signed_op == last_s) e.short_path = 1;
`endif
    e.seen = 0;
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    req_t r;
    r.op = op; r.a = a; r.b = b; r.tag = tag;
    req_q.push_back(r);
  endtask

  // One clock cycle: drive all inputs at the falling edge, settle, then score
  task automatic step();
    req_t r;
    exp_t e;
    @(negedge clock);
    cyc++;
    if (req_q.size() > 0) begin
      req_valid_i = 1'b1;
      req_op_i = req_q[0].op; req_a_i = req_q[0].a; req_b_i = req_q[0].b; req_tag_i = req_q[0].tag;
    end else begin
      req_valid_i = 1'b0;
    end
    if (core_in_valid_o) begin
      if (in_stall_cnt > 0) begin core_in_ready_i = 1'b0; in_stall_cnt--; end
      else core_in_ready_i = 1'b1;
    end else begin
      core_in_ready_i = 1'b0; in_stall_cnt = in_stall_len;
    end
    core_out_valid_i = 1'b0;
    if (core_pend) begin
      if (lat_cnt > 0) lat_cnt--;
      else begin core_out_valid_i = 1'b1; core_quot_i = core_q; core_rem_i = core_r; end
    end
    if (rsp_valid_o) begin
      if (rsp_stall_cnt > 0) begin rsp_ready_i = 1'b0; rsp_stall_cnt--; end
      else rsp_ready_i = 1'b1;
    end else begin
      rsp_ready_i = 1'b0; rsp_stall_cnt = rsp_stall_len;
    end
    #1;
    if (hold_rsp) begin
      check("rsp_hold_valid", 32'(rsp_valid_o), 32'd1);
      check("rsp_hold_data", rsp_data_o, hold_data);
      check("rsp_hold_tag", 32'(rsp_tag_o), 32'(hold_tag));
    end
    if (hold_core) begin
      check("core_hold_valid", 32'(core_in_valid_o), 32'd1);
      check("core_hold_a", core_a_o, hold_ca);
      check("core_hold_b", core_b_o, hold_cb);
    end
    if (rsp_valid_o) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else begin
        if (!exp_q[0].seen) begin
          exp_q[0].seen = 1;
          if (exp_q[0].short_path) check("short_latency", cyc - exp_q[0].acc_cyc, 32'd1);
        end
        if (rsp_ready_i) begin
          check("rsp_data", rsp_data_o, exp_q[0].data);
          check("rsp_tag", 32'(rsp_tag_o), 32'(exp_q[0].tag));
          $display("rsp tag=%0d a=%08h b=%08h data=%08h", rsp_tag_o, exp_q[0].a, exp_q[0].b, rsp_data_o);
          if (req_valid_i) check("retire_accept", 32'(req_ready_o), 32'd1);
          void'(exp_q.pop_front());
          rsp_stall_cnt = rsp_stall_len;
        end else begin
          check("stall_req_ready", 32'(req_ready_o), 32'd0);
        end
      end
    end
    hold_rsp = rsp_valid_o && !rsp_ready_i;
    hold_data = rsp_data_o; hold_tag = rsp_tag_o;
    if (core_in_valid_o && core_in_ready_i) begin
      core_xfers++;
      if (exp_q.size() == 0 || exp_q[0].short_path) check("core_unexpected", 32'd1, 32'd0);
      else begin
        check("core_a", core_a_o, exp_q[0].mag_a);
        check("core_b", core_b_o, exp_q[0].mag_b);
      end
      core_pend = 1; lat_cnt = core_lat;
      core_q = (core_b_o == 0) ? 32'hFFFF_FFFF : core_a_o / core_b_o;
      core_r = (core_b_o == 0) ? core_a_o : core_a_o % core_b_o;
    end
    hold_core = core_in_valid_o && !core_in_ready_i;
    hold_ca = core_a_o; hold_cb = core_b_o;
    if (core_out_valid_i && core_out_ready_o) begin
      core_pend = 0;
      if (exp_q.size() > 0) begin
        last_a = exp_q[0].a; last_b = exp_q[0].b; last_s = exp_q[0].signed_op; last_v = 1;
      end
    end
    if (req_valid_i && req_ready_o) begin
      r = req_q.pop_front();
      e = build_exp(r);
      e.acc_cyc = cyc;
      if (!e.short_path) normal_accepts++;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_all(input int budget);
    int n = 0;
    while ((req_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("run_timeout", 32'(req_q.size() + exp_q.size()), 32'd0);
    check("core_xfer_count", core_xfers, normal_accepts);
    step();
    check("idle_after_run", 32'(busy_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "_rsp_data"}, rsp_data_o, 32'd0);
    check({tag, "_rsp_tag"}, 32'(rsp_tag_o), 32'd0);
    check({tag, "_core_in_valid"}, 32'(core_in_valid_o), 32'd0);
    check({tag, "_core_out_ready"}, 32'(core_out_ready_o), 32'd0);
    check({tag, "_core_ab"}, core_a_o | core_b_o, 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      4: return 32'(-$urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int x0;
    int n;
    logic [31:0] ra, rb;
    nreset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_reset_outputs("reset");
    nreset = 1'b1;

    // Directed RV32M cases, including the locally resolved ones
    push(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3);
    push(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4);
    push(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5);
    push(2'b01, 32'hFFFF_FFFE, 32'd2, 5'd6);
    push(2'b00, 32'd5, 32'd0, 5'd7);
    push(2'b10, 32'd5, 32'd0, 5'd8);
    push(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    push(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    push(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_all(400);

    // Handshake stress: core input stall and long response stall
    in_stall_len = 4; rsp_stall_len = 6; core_lat = 3;
    push(2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd12);
    push(2'b10, 32'hFFFF_FC18, 32'd7, 5'd13);
    push(2'b00, 32'd9, 32'd0, 5'd14);
    run_all(400);

    // Divide then remainder on identical operands
    in_stall_len = 0; rsp_stall_len = 0; core_lat = 2;
    x0 = core_xfers;
    push(2'b00, 32'd100, 32'd7, 5'd1);
    push(2'b10, 32'd100, 32'd7, 5'd2);
    run_all(200);
`ifdef DIV_CTRL_REUSE_EN
    check("reuse_core_xfers", core_xfers - x0, 32'd1);
`else
    check("reuse_core_xfers", core_xfers - x0, 32'd2);
`endif

    // Randomized batches with random stalls and core latency
    ra = 32'd1; rb = 32'd1;
    for (int batch = 0; batch < 10; batch++) begin
      in_stall_len = $urandom_range(0, 3);
      rsp_stall_len = $urandom_range(0, 4);
      core_lat = $urandom_range(0, 4);
      for (int i = 0; i < 15; i++) begin
        if ($urandom_range(0, 3) != 0) begin ra = pick_operand(); rb = pick_operand(); end
        push(2'($urandom_range(0, 3)), ra, rb, 5'($urandom_range(0, 31)));
      end
      run_all(3000);
    end

    // Reset while waiting on the core; the late core result must be ignored
    in_stall_len = 0; rsp_stall_len = 0; core_lat = 12;
    push(2'b01, 32'd1000, 32'd3, 5'd21);
    n = 0;
    while (!core_out_ready_o && n < 50) begin step(); n++; end
    check("reach_wait", 32'(core_out_ready_o), 32'd1);
    @(negedge clock);
    nreset = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clock);
    nreset = 1'b1;
    exp_q.delete();
    req_q.delete();
    hold_rsp = 0; hold_core = 0; last_v = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("late_core_ready", 32'(core_out_ready_o), 32'd0);
      check("late_rsp_valid", 32'(rsp_valid_o), 32'd0);
    end
    check("late_core_ignored", 32'(core_pend), 32'd1);
    core_pend = 0;
    core_lat = 1;
    push(2'b00, 32'd100, 32'd7, 5'd22);
    push(2'b10, 32'd100, 32'd7, 5'd23);
    run_all(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "time limit");
  end

endmodule
